// File: rtl/cpu_run_pkg.sv
// Shared types for the processor run controller: FSM state encoding and PC width.
package cpu_run_pkg;

    localparam int PC_W = 64;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RST_HOLD = 3'd1,
        RUN      = 3'd2,
        DONE     = 3'd3,
        TIMEOUT  = 3'd4
    } state_t;

endpackage

// File: rtl/cpu_run_ctrl.sv
// Sequences one program run: reset hold with start PC, counted RUN phase, stop/watchdog capture.
// Optional single-step control is compiled in with `define STEP_MODE_EN.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  start_pc,
    input  logic [PC_W-1:0]  stop_pc,
    input  logic [CNT_W-1:0] max_cycles,
    input  logic [PC_W-1:0]  currentpc,
    input  logic [PC_W-1:0]  cpu_result,
`ifdef STEP_MODE_EN
    input  logic             step_mode,
    input  logic             step,
`endif
    output logic             cpu_resetl,
    output logic             cpu_en,
    output logic [PC_W-1:0]  startpc,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [PC_W-1:0]  result,
    output logic [CNT_W-1:0] cycles
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t           state_reg;
    logic [RST_W-1:0] rst_cnt_reg;
    logic [PC_W-1:0]  stop_pc_reg;
    logic [CNT_W-1:0] max_cycles_reg;
    logic [CNT_W-1:0] cycles_reg;
    logic [PC_W-1:0]  startpc_reg;
    logic [PC_W-1:0]  result_reg;
    logic             cpu_resetl_reg;
    logic             cpu_en_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             timeout_reg;

    logic             advance;
    logic             launch;
    logic             stop_hit;
    logic             wdog_hit;
    logic [CNT_W:0]   cycles_inc;

`ifdef STEP_MODE_EN
    // In step mode the CPU, the counter and the stop checks all move only on step pulses.
    assign advance = !step_mode || step;
    assign cpu_en  = (state_reg == RUN && step_mode) ? step : cpu_en_reg;
`else
    assign advance = 1'b1;
    assign cpu_en  = cpu_en_reg;
`endif

    assign launch     = start && (state_reg == IDLE || state_reg == DONE || state_reg == TIMEOUT);
    assign cycles_inc = {1'b0, cycles_reg} + (CNT_W + 1)'(1);
    assign stop_hit   = (currentpc >= stop_pc_reg);
    assign wdog_hit   = (max_cycles_reg != '0) && (cycles_inc == {1'b0, max_cycles_reg});

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            rst_cnt_reg    <= '0;
            stop_pc_reg    <= '0;
            max_cycles_reg <= '0;
            cycles_reg     <= '0;
            startpc_reg    <= '0;
            result_reg     <= '0;
            cpu_resetl_reg <= 1'b0;
            cpu_en_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE, TIMEOUT: begin
                    if (launch) begin
                        state_reg      <= RST_HOLD;
                        startpc_reg    <= start_pc;
                        stop_pc_reg    <= stop_pc;
                        max_cycles_reg <= max_cycles;
                        cycles_reg     <= '0;
                        result_reg     <= '0;
                        rst_cnt_reg    <= '0;
                        cpu_resetl_reg <= 1'b0;
                        cpu_en_reg     <= 1'b1;
                        busy_reg       <= 1'b1;
                        done_reg       <= 1'b0;
                        timeout_reg    <= 1'b0;
                    end
                end
                RST_HOLD: begin
                    if (rst_cnt_reg == RST_W'(RST_CYCLES - 1)) begin
                        state_reg      <= RUN;
                        cpu_resetl_reg <= 1'b1;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg + 1'b1;
                    end
                end
                RUN: begin
                    if (advance) begin
                        // Saturate rather than wrap so a runaway program still reads as "long".
                        cycles_reg <= cycles_inc[CNT_W] ? cycles_reg : cycles_inc[CNT_W-1:0];
                        if (stop_hit) begin
                            state_reg  <= DONE;
                            result_reg <= cpu_result;
                            cpu_en_reg <= 1'b0;
                            busy_reg   <= 1'b0;
                            done_reg   <= 1'b1;
                        end else if (wdog_hit) begin
                            state_reg   <= TIMEOUT;
                            result_reg  <= cpu_result;
                            cpu_en_reg  <= 1'b0;
                            busy_reg    <= 1'b0;
                            timeout_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cpu_resetl = cpu_resetl_reg;
    assign startpc    = startpc_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign timeout    = timeout_reg;
    assign result     = result_reg;
    assign cycles     = cycles_reg;

endmodule
